// File: rtl/capi_pkg.sv
// Shared CAPI/PSL definitions: response codes, WED error codes and receiver states.
// Used by wed_receiver; parity checking is selected there by PARITY_CHECK_EN.
package capi_pkg;

    localparam logic [7:0] RESP_DONE      = 8'h00;
    localparam logic [7:0] RESP_AERROR    = 8'h01;
    localparam logic [7:0] RESP_DERROR    = 8'h03;
    localparam logic [7:0] RESP_NLOCK     = 8'h04;
    localparam logic [7:0] RESP_NRES      = 8'h05;
    localparam logic [7:0] RESP_FLUSHED   = 8'h06;
    localparam logic [7:0] RESP_FAULT     = 8'h07;
    localparam logic [7:0] RESP_FAILED    = 8'h08;
    localparam logic [7:0] RESP_PAGED     = 8'h0A;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_BAD_RESP     = 3'd1,
        ERR_MISSING_HALF = 3'd2,
        ERR_TIMEOUT      = 3'd3,
        ERR_PARITY       = 3'd4
    } wed_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } wed_state_e;

endpackage

// File: rtl/capi_parity_chk.sv
// Odd-parity check of a W-bit field: ok is high when par equals ~^data.
// Instanced by wed_receiver only when PARITY_CHECK_EN is defined.
module capi_parity_chk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] data,
    input  logic         par,
    output logic         ok
);

    function automatic logic odd_par(input logic [W-1:0] d);
        return ~^d;
    endfunction

    assign ok = (par == odd_par(data));

endmodule

// File: rtl/wed_receiver.sv
// Captures the 128-byte WED from the PSL buffer-write bus and resolves it on the
// matching response. Optional macro PARITY_CHECK_EN enables tag/data parity checks.
module wed_receiver
    import capi_pkg::*;
#(
    parameter logic [7:0]  WED_TAG        = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           arm,
    input  logic           ha_bwvalid,
    input  logic [7:0]     ha_bwtag,
    input  logic           ha_bwtagpar,
    input  logic [5:0]     ha_bwad,
    input  logic [0:511]   ha_bwdata,
    input  logic [0:7]     ha_bwpar,
    input  logic           ha_rvalid,
    input  logic [7:0]     ha_rtag,
    input  logic           ha_rtagpar,
    input  logic [7:0]     ha_response,
    output logic           wed_valid,
    output logic [0:1023]  wed_data,
    output logic           wed_error,
    output logic [2:0]     wed_err_code,
    output logic [7:0]     wed_err_resp
);

    wed_state_e        state_q, state_d;
    wed_err_e          code_q, code_d, fail_code_s;
    logic [0:1023]     data_q, data_d;
    logic [1:0]        half_q, half_d, half_after_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d, error_q, error_d;
    logic [7:0]        resp_q, resp_d;

    logic bw_hit_s, r_hit_s, bw_par_ok_s, r_par_ok_s, bw_wr_s, timeout_s;

`ifdef PARITY_CHECK_EN
    logic       bwtag_ok_s;
    logic [7:0] dw_ok_s;

    capi_parity_chk #(.W(8)) u_bwtag_chk (.data(ha_bwtag), .par(ha_bwtagpar), .ok(bwtag_ok_s));
    capi_parity_chk #(.W(8)) u_rtag_chk  (.data(ha_rtag),  .par(ha_rtagpar),  .ok(r_par_ok_s));

    for (genvar g = 0; g < 8; g++) begin : g_dw_chk
        capi_parity_chk #(.W(64)) u_dw_chk (
            .data (ha_bwdata[g*64 +: 64]),
            .par  (ha_bwpar[g]),
            .ok   (dw_ok_s[g])
        );
    end

    assign bw_par_ok_s = bwtag_ok_s & (&dw_ok_s);
`else
    logic unused_par_s;
    assign unused_par_s = ^{ha_bwtagpar, ha_bwpar, ha_rtagpar};
    assign bw_par_ok_s  = 1'b1;
    assign r_par_ok_s   = 1'b1;
`endif

    assign bw_hit_s  = ha_bwvalid && (ha_bwtag == WED_TAG);
    assign r_hit_s   = ha_rvalid && (ha_rtag == WED_TAG);
    assign bw_wr_s   = (state_q == ST_ARMED) && bw_hit_s && bw_par_ok_s &&
                       ((ha_bwad == 6'd0) || (ha_bwad == 6'd1));
    // A write landing in the response cycle already counts toward completeness.
    assign half_after_s = half_q | {bw_wr_s && (ha_bwad == 6'd1), bw_wr_s && (ha_bwad == 6'd0)};
    assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decision; error priority: parity, bad response, missing half, timeout.
    always_comb begin
        state_d     = state_q;
        fail_code_s = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (arm) state_d = ST_ARMED;
                else     state_d = state_q;
            end
            ST_ARMED: begin
                if (bw_hit_s && !bw_par_ok_s) begin
                    state_d = ST_ERROR; fail_code_s = ERR_PARITY;
                end else if (r_hit_s && !r_par_ok_s) begin
                    state_d = ST_ERROR; fail_code_s = ERR_PARITY;
                end else if (r_hit_s && (ha_response != RESP_DONE)) begin
                    state_d = ST_ERROR; fail_code_s = ERR_BAD_RESP;
                end else if (r_hit_s && (half_after_s == 2'b11)) begin
                    state_d = ST_DONE;
                end else if (r_hit_s) begin
                    state_d = ST_ERROR; fail_code_s = ERR_MISSING_HALF;
                end else if (timeout_s) begin
                    state_d = ST_ERROR; fail_code_s = ERR_TIMEOUT;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and status next values.
    always_comb begin
        data_d  = data_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        error_d = error_q;
        code_d  = code_q;
        resp_d  = resp_q;
        if (state_q == ST_ARMED) begin
            cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            half_d = half_after_s;
            if (bw_wr_s && (ha_bwad == 6'd0))      data_d[0 +: 512]   = ha_bwdata;
            else if (bw_wr_s)                      data_d[512 +: 512] = ha_bwdata;
            else                                   data_d = data_q;
            if (state_d == ST_DONE) begin
                valid_d = 1'b1;
            end else if (state_d == ST_ERROR) begin
                error_d = 1'b1;
                code_d  = fail_code_s;
                resp_d  = (fail_code_s == ERR_BAD_RESP) ? ha_response : 8'h00;
            end else begin
                valid_d = valid_q;
            end
        end else if (state_d == ST_ARMED) begin
            cnt_d   = '0;
            half_d  = 2'b00;
            valid_d = 1'b0;
            error_d = 1'b0;
            code_d  = ERR_NONE;
            resp_d  = 8'h00;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            half_q  <= 2'b00;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
            resp_q  <= 8'h00;
        end else begin
            data_q  <= data_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            error_q <= error_d;
            code_q  <= code_d;
            resp_q  <= resp_d;
        end
    end

    assign wed_valid    = valid_q;
    assign wed_data     = data_q;
    assign wed_error    = error_q;
    assign wed_err_code = code_q;
    assign wed_err_resp = resp_q;

endmodule

// File: tb/tb_wed_receiver.sv
// Self-checking bench for wed_receiver against a transaction-level WED model.
// Build with or without PARITY_CHECK_EN; expectations follow the macro.
module tb_wed_receiver;

    localparam int TMO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic          ha_bwvalid;
    logic [7:0]    ha_bwtag;
    logic          ha_bwtagpar;
    logic [5:0]    ha_bwad;
    logic [0:511]  ha_bwdata;
    logic [0:7]    ha_bwpar;
    logic          ha_rvalid;
    logic [7:0]    ha_rtag;
    logic          ha_rtagpar;
    logic [7:0]    ha_response;
    logic          wed_valid;
    logic [0:1023] wed_data;
    logic          wed_error;
    logic [2:0]    wed_err_code;
    logic [7:0]    wed_err_resp;

    wed_receiver #(.WED_TAG(8'hFF), .TIMEOUT_CYCLES(TMO), .CNT_W(13)) dut (
        .clock(clock), .reset(reset), .arm(arm),
        .ha_bwvalid(ha_bwvalid), .ha_bwtag(ha_bwtag), .ha_bwtagpar(ha_bwtagpar),
        .ha_bwad(ha_bwad), .ha_bwdata(ha_bwdata), .ha_bwpar(ha_bwpar),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_rtagpar(ha_rtagpar),
        .ha_response(ha_response),
        .wed_valid(wed_valid), .wed_data(wed_data), .wed_error(wed_error),
        .wed_err_code(wed_err_code), .wed_err_resp(wed_err_resp)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 idle, 1 waiting for WED, 2 complete, 3 failed
    int            m_st;
    int            m_age;
    logic [0:1023] m_data;
    logic [1:0]    m_half;
    logic          m_valid, m_error;
    logic [2:0]    m_code;
    logic [7:0]    m_resp;

    function automatic logic [0:7] gen_par(input logic [0:511] d);
        logic [0:7] p;
        for (int i = 0; i < 8; i++) p[i] = ~^d[i*64 +: 64];
        return p;
    endfunction

    function automatic logic [0:511] rand_half();
        logic [0:511] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"},   512'(wed_valid),    512'(m_valid));
        chk({tag, "_error"},   512'(wed_error),    512'(m_error));
        chk({tag, "_code"},    512'(wed_err_code), 512'(m_code));
        chk({tag, "_resp"},    512'(wed_err_resp), 512'(m_resp));
        chk({tag, "_data_lo"}, wed_data[0:511],    m_data[0:511]);
        chk({tag, "_data_hi"}, wed_data[512:1023], m_data[512:1023]);
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_data = '0; m_half = 2'b00;
        m_valid = 1'b0; m_error = 1'b0; m_code = 3'd0; m_resp = 8'h00;
    endtask

    task automatic model_fail(input logic [2:0] c, input logic [7:0] r);
        m_st = 3; m_error = 1'b1; m_code = c; m_resp = r;
    endtask

    // Effect of the current inputs at the coming clock edge.
    task automatic model_step();
        logic bw_ok, r_ok;
        if (m_st != 1) begin
            if (arm) begin
                m_st = 1; m_age = 0; m_half = 2'b00;
                m_valid = 1'b0; m_error = 1'b0; m_code = 3'd0; m_resp = 8'h00;
            end
            return;
        end
        m_age++;
        bw_ok = 1'b1;
        r_ok  = 1'b1;
`ifdef PARITY_CHECK_EN
        bw_ok = (ha_bwtagpar == ~^ha_bwtag) && (ha_bwpar == gen_par(ha_bwdata));
        r_ok  = (ha_rtagpar == ~^ha_rtag);
`endif
        if (ha_bwvalid && ha_bwtag == 8'hFF) begin
            if (!bw_ok) begin model_fail(3'd4, 8'h00); return; end
            if (ha_bwad == 6'd0) begin m_data[0:511] = ha_bwdata; m_half[0] = 1'b1; end
            if (ha_bwad == 6'd1) begin m_data[512:1023] = ha_bwdata; m_half[1] = 1'b1; end
        end
        if (ha_rvalid && ha_rtag == 8'hFF) begin
            if (!r_ok)                     model_fail(3'd4, 8'h00);
            else if (ha_response != 8'h00) model_fail(3'd1, ha_response);
            else if (m_half == 2'b11)      begin m_st = 2; m_valid = 1'b1; end
            else                           model_fail(3'd2, 8'h00);
            return;
        end
        if (m_age >= TMO) model_fail(3'd3, 8'h00);
    endtask

    task automatic idle();
        arm = 1'b0; ha_bwvalid = 1'b0; ha_rvalid = 1'b0;
    endtask

    task automatic set_bw(input logic [7:0] tag, input logic [5:0] ad, input logic [0:511] d);
        ha_bwvalid = 1'b1; ha_bwtag = tag; ha_bwtagpar = ~^tag;
        ha_bwad = ad; ha_bwdata = d; ha_bwpar = gen_par(d);
    endtask

    task automatic set_resp(input logic [7:0] tag, input logic [7:0] code);
        ha_rvalid = 1'b1; ha_rtag = tag; ha_rtagpar = ~^tag; ha_response = code;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clock);
        #1;
        idle();
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        ha_bwtag = 8'h00; ha_bwtagpar = 1'b1; ha_bwad = 6'd0; ha_bwdata = '0; ha_bwpar = 8'hFF;
        ha_rtag = 8'h00; ha_rtagpar = 1'b1; ha_response = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clock); #1;
        reset = 1'b1;

        // Ordered halves, stray arm while waiting is ignored
        arm = 1'b1;                                  step("t1_arm");
        set_bw(8'hFF, 6'd0, rand_half());            step("t1_bw0");
        arm = 1'b1; set_bw(8'hFF, 6'd1, rand_half()); step("t1_bw1");
        set_resp(8'hFF, 8'h00);                      step("t1_done");
        step("t1_hold");

        // Reversed halves, ad0 coincides with the response
        arm = 1'b1;                                  step("t2_arm");
        set_bw(8'hFF, 6'd1, rand_half());            step("t2_bw1");
        set_bw(8'hFF, 6'd0, rand_half()); set_resp(8'hFF, 8'h00); step("t2_done");

        // Missing half; out-of-range address ignored
        arm = 1'b1;                                  step("t3_arm");
        set_bw(8'hFF, 6'd0, rand_half());            step("t3_bw0");
        set_bw(8'hFF, 6'd2, rand_half());            step("t3_bw2");
        set_resp(8'hFF, 8'h00);                      step("t3_missing");

        // Foreign-tag traffic, then bad response code
        arm = 1'b1;                                  step("t4_arm");
        set_bw(8'h01, 6'd0, rand_half());            step("t4_fbw0");
        set_resp(8'h01, 8'h00);                      step("t4_fresp");
        set_bw(8'h01, 6'd1, rand_half()); set_resp(8'h01, 8'h05); step("t4_fboth");
        set_bw(8'hFF, 6'd0, rand_half());            step("t4_bw0");
        set_bw(8'hFF, 6'd1, rand_half());            step("t4_bw1");
        set_resp(8'hFF, 8'h05);                      step("t4_bad");

        // Timeout, re-arm clears, then reset mid-transfer
        arm = 1'b1;                                  step("t5_arm");
        for (int i = 0; i < TMO + 3; i++)            step("t5_wait");
        arm = 1'b1;                                  step("t5_rearm");
        set_bw(8'hFF, 6'd0, rand_half());            step("t5_bw0");
        reset = 1'b0;
        #2;
        model_reset();
        check_all("t5_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        step("t5_post");

        // Corrupted doubleword parity on ad0
        arm = 1'b1;                                  step("t6_arm");
        set_bw(8'hFF, 6'd0, rand_half()); ha_bwpar[3] = ~ha_bwpar[3]; step("t6_badpar");
        set_bw(8'hFF, 6'd1, rand_half());            step("t6_bw1");
        set_resp(8'hFF, 8'h00);                      step("t6_resp");

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            arm = 1'b1;                              step("rnd_arm");
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(3, 0) != 0)
                    set_bw(($urandom_range(3, 0) == 0) ? 8'h01 : 8'hFF,
                           6'($urandom_range(2, 0)), rand_half());
                if ($urandom_range(7, 0) == 0)
                    set_resp(8'h01, 8'($urandom_range(255, 0)));
                step("rnd_mid");
            end
            set_resp(8'hFF, ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'h00);
            step("rnd_resp");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
